nn_acc_burst_master: RTL
========================

Name: nn_acc_burst_master

Overview:
Avalon-MM burst initiator that drives the single-MAC accelerator's slave port. It pulls 32-bit float words from a local source stream and burst-writes 96 weights, then 96 image words, per result. It waits out the calculation, repeats for the requested number of results, then burst-reads the results back onto a result stream. It sits between the Nios-side DMA/FIFO logic and the accelerator slave.

Parameters:
WEIGHT_BASE, 8'h01, accelerator address for weight burst writes
IMAGE_BASE, 8'h61, accelerator address for image burst writes
RESULT_BASE, 8'hC1, accelerator address for result burst reads
VEC_WORDS, 96, words per weight burst and per image burst
MAX_RESULTS, 24, maximum results per job (result buffer depth)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  job start pulse; sampled in IDLE only
num_results  in  5  results per job, 0..MAX_RESULTS; latched on start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at job completion
src_data  in  32  weight/image word stream (weights first, then image, per pass)
src_valid  in  1  src_data valid
src_ready  out  1  word consumed this cycle
res_data  out  32  result word
res_valid  out  1  one-cycle pulse per result, no backpressure
address  out  8  Avalon address
read  out  1  Avalon read
write  out  1  Avalon write
beginbursttransfer  out  1  Avalon burst start, one cycle per burst
burstcount  out  11  Avalon burst length
writedata  out  32  Avalon write data
waitrequest  in  1  Avalon stall
readdatavalid  in  1  Avalon read data valid (may coincide with the read cycle)
readdata  in  32  Avalon read data

Behaviour:
- Reset (asynchronous, any state): state IDLE. All outputs 0, counters 0, latched num_results 0. Any in-flight burst is abandoned.
- States: IDLE, W_BEGIN, W_DATA, I_BEGIN, I_DATA, CALC_WAIT, R_BEGIN, R_DATA, DONE.
- IDLE: on start, latch num_results into n_res and clear pass_cnt.
  - n_res==0: go to DONE directly, with no bus activity.
  - Otherwise go to W_BEGIN. busy=1 from the next cycle.
- *_BEGIN (write bursts): exactly one cycle with beginbursttransfer=1, address=base, burstcount=VEC_WORDS, write=0. Load word_cnt=VEC_WORDS. Next state is the matching *_DATA.
- W_DATA / I_DATA:
  - Drive write=src_valid, writedata=src_data, address=base.
  - Accept condition: write && !waitrequest. src_ready equals the accept condition (combinational on waitrequest).
  - While waitrequest=1: hold write and writedata stable and do not consume.
  - src_valid=0 mid-burst: write=0 and the burst stays open. No timeout.
  - On each accept, word_cnt decrements. The accept that takes word_cnt 1->0 exits: W_DATA->I_BEGIN, I_DATA->CALC_WAIT.
- CALC_WAIT: one mandatory settle cycle, then stay while waitrequest=1. When waitrequest=0: pass_cnt++.
  - pass_cnt==n_res: go to R_BEGIN.
  - Otherwise go to W_BEGIN.
- R_BEGIN: one cycle with beginbursttransfer=1, address=RESULT_BASE, burstcount=n_res (zero-extended to 11 bits), read=0. Load word_cnt=n_res.
- R_DATA:
  - read=1, address=RESULT_BASE.
  - Each cycle readdatavalid=1: register readdata into res_data, pulse res_valid in the next cycle, and decrement word_cnt.
  - Exit to DONE when word_cnt reaches 0. read drops in the cycle after the last readdatavalid.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start while busy is ignored.
- At most one of read/write/beginbursttransfer is high in any cycle. address and burstcount are held constant for the whole burst.
- word_cnt is 11 bits and does not wrap, because the decrement is gated by the nonzero state.
- num_results > MAX_RESULTS is clamped to MAX_RESULTS at latch time.
- res_data holds its last value between pulses. Reset value is 0.

Decomposition:
- Package nn_acc_pkg:
  - state enum nn_mst_state_t
  - address constants (WEIGHT_BASE, IMAGE_BASE, RESULT_BASE)
  - VEC_WORDS and MAX_RESULTS defaults
  - burstcount width constant (11)
- One natural sub-module: nn_burst_counter. It is a loadable down-counter with an accept-decrement input and a last flag, shared by the write and read phases.

Test Plan:
- num_results=1, src always valid, slave model never stalls outside begin/calc:
  - Required bus traffic: one begin at 8'h01/96, 96 writes; one begin at 8'h61/96, 96 writes; then begin read at 8'hC1/1.
  - With weights=1.0 and image=2.0, res_data=32'h43400000 (192.0).
  - Then one done pulse.
- Stalls: src_valid toggled every 3rd cycle and waitrequest randomly high 30% of the time.
  - Exactly 192 accepted writes; writedata stable during stalls; the word order written equals the source order.
- num_results=3 with distinct vectors:
  - 3 write-pass pairs, each preceded by a CALC_WAIT with waitrequest low before the next begin.
  - One read burst with burstcount=3; 3 res_valid pulses in order.
- num_results=0: done pulses 2 cycles after start; address/read/write/beginbursttransfer all stay 0.
- Reset asserted mid-I_DATA after 40 image words:
  - All outputs go to 0 immediately; state IDLE.
  - A new start with num_results=1 completes correctly after the slave is reset too.
- start pulsed while busy and num_results=30:
  - The busy-time start is ignored.
  - The clamp produces a read burstcount of 24 on a separate job.

Source files
------------

// File: rtl/nn_acc_pkg.sv
// Shared types and constants for the single-MAC accelerator burst master.
package nn_acc_pkg;

  localparam logic [7:0]  WEIGHT_BASE = 8'h01;
  localparam logic [7:0]  IMAGE_BASE  = 8'h61;
  localparam logic [7:0]  RESULT_BASE = 8'hC1;

  localparam int unsigned VEC_WORDS   = 96;
  localparam int unsigned MAX_RESULTS = 24;

  localparam int unsigned BURST_CNT_W = 11;

  typedef enum logic [3:0] {
    StIdle,
    StWBegin,
    StWData,
    StIBegin,
    StIData,
    StCalcWait,
    StRBegin,
    StRData,
    StDone
  } nn_mst_state_t;

endpackage

// File: rtl/nn_burst_counter.sv
// Loadable burst down-counter; flags the final beat so the FSM can close the burst.
module nn_burst_counter #(
  parameter int unsigned Width = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Decrement is gated on nonzero so a stray beat can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == {{(Width-1){1'b0}}, 1'b1});

endmodule

// File: rtl/nn_acc_burst_master.sv
// Avalon-MM burst initiator: streams weight/image vectors into the MAC accelerator per
// result, waits for each calculation, then burst-reads all results onto a result stream.
module nn_acc_burst_master #(
  parameter logic [7:0]  WEIGHT_BASE = nn_acc_pkg::WEIGHT_BASE,
  parameter logic [7:0]  IMAGE_BASE  = nn_acc_pkg::IMAGE_BASE,
  parameter logic [7:0]  RESULT_BASE = nn_acc_pkg::RESULT_BASE,
  parameter int unsigned VEC_WORDS   = nn_acc_pkg::VEC_WORDS,
  parameter int unsigned MAX_RESULTS = nn_acc_pkg::MAX_RESULTS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  num_results,
  output logic        busy,
  output logic        done,
  input  logic [31:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [31:0] res_data,
  output logic        res_valid,
  output logic [7:0]  address,
  output logic        read,
  output logic        write,
  output logic        beginbursttransfer,
  output logic [10:0] burstcount,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  input  logic [31:0] readdata
);

  import nn_acc_pkg::*;

  localparam logic [BURST_CNT_W-1:0] VecWords = BURST_CNT_W'(VEC_WORDS);
  localparam logic [4:0]             MaxRes   = 5'(MAX_RESULTS);

  nn_mst_state_t state_q, state_d;

  logic [4:0]  n_res_q, n_res_d;
  logic [4:0]  pass_cnt_q, pass_cnt_d;
  logic        settled_q, settled_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_valid_q, res_valid_d;

  logic                   cnt_load;
  logic [BURST_CNT_W-1:0] cnt_load_val;
  logic                   cnt_dec;
  logic                   cnt_last;

  logic [BURST_CNT_W-1:0] res_burst_len;
  logic                   is_weight;

  assign res_burst_len = {{(BURST_CNT_W-5){1'b0}}, n_res_q};
  assign is_weight     = (state_q == StWBegin) || (state_q == StWData);

  nn_burst_counter #(
    .Width (BURST_CNT_W)
  ) u_burst_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d            = state_q;
    n_res_d            = n_res_q;
    pass_cnt_d         = pass_cnt_q;
    settled_d          = 1'b0;
    res_data_d         = res_data_q;
    res_valid_d        = 1'b0;
    cnt_load           = 1'b0;
    cnt_load_val       = '0;
    cnt_dec            = 1'b0;
    busy               = 1'b1;
    done               = 1'b0;
    src_ready          = 1'b0;
    address            = '0;
    read               = 1'b0;
    write              = 1'b0;
    beginbursttransfer = 1'b0;
    burstcount         = '0;
    writedata          = '0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          n_res_d    = (num_results > MaxRes) ? MaxRes : num_results;
          pass_cnt_d = '0;
          state_d    = (num_results == 5'd0) ? StDone : StWBegin;
        end
      end

      StWBegin, StIBegin: begin
        beginbursttransfer = 1'b1;
        address            = is_weight ? WEIGHT_BASE : IMAGE_BASE;
        burstcount         = VecWords;
        cnt_load           = 1'b1;
        cnt_load_val       = VecWords;
        state_d            = is_weight ? StWData : StIData;
      end

      // write follows the source directly; a stalled word stays on the bus because the
      // source cannot advance until src_ready.
      StWData, StIData: begin
        address    = is_weight ? WEIGHT_BASE : IMAGE_BASE;
        burstcount = VecWords;
        write      = src_valid;
        writedata  = src_data;
        src_ready  = src_valid && !waitrequest;
        cnt_dec    = src_ready;
        if (src_ready && cnt_last) begin
          state_d = is_weight ? StIBegin : StCalcWait;
        end
      end

      // First cycle ignores waitrequest so the slave has time to raise it for the calc.
      StCalcWait: begin
        if (settled_q && !waitrequest) begin
          pass_cnt_d = pass_cnt_q + 5'd1;
          state_d    = ((pass_cnt_q + 5'd1) == n_res_q) ? StRBegin : StWBegin;
        end else begin
          settled_d = 1'b1;
        end
      end

      StRBegin: begin
        beginbursttransfer = 1'b1;
        address            = RESULT_BASE;
        burstcount         = res_burst_len;
        cnt_load           = 1'b1;
        cnt_load_val       = res_burst_len;
        state_d            = StRData;
      end

      StRData: begin
        read       = 1'b1;
        address    = RESULT_BASE;
        burstcount = res_burst_len;
        cnt_dec    = readdatavalid;
        if (readdatavalid) begin
          res_data_d  = readdata;
          res_valid_d = 1'b1;
          if (cnt_last) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      n_res_q     <= '0;
      pass_cnt_q  <= '0;
      settled_q   <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_res_q     <= n_res_d;
      pass_cnt_q  <= pass_cnt_d;
      settled_q   <= settled_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;

endmodule
